// File: rtl/rv64g_l1_pkg.sv
// Shared L1 cache definitions: PLRU FSM states, heap-tree index helpers and
// default geometry.
package rv64g_l1_pkg;

  localparam int DEF_SETS = 32;
  localparam int DEF_WAYS = 8;

  typedef enum logic [0:0] {
    PLRU_INIT = 1'b0,
    PLRU_RUN  = 1'b1
  } plru_state_e;

  function automatic int node_left(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int node_right(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int node_parent(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/rv64g_l1_plru_pick.sv
// Combinational victim pick: lowest invalid way first, else PLRU tree walk.
// With RV64G_L1_PLRU_LOCK_EN defined, locked ways are never chosen.
module rv64g_l1_plru_pick
  import rv64g_l1_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree,
  input  logic [WAYS-1:0]  vmask,
  input  logic [WAYS-1:0]  lock_mask,
  output logic [WAY_W-1:0] way,
  output logic             none
);

  logic [WAYS-1:0] avail;

`ifdef RV64G_L1_PLRU_LOCK_EN
  assign avail = ~lock_mask;
`else
  logic unused_lock;
  assign avail       = '1;
  assign unused_lock = ^lock_mask;
`endif

  always_comb begin
    logic            found;
    logic            go_r;
    logic [WAYS-1:0] lmask;
    logic [WAYS-1:0] rmask;
    int              node;
    int              base;
    int              span;
    way   = '0;
    none  = 1'b0;
    found = 1'b0;
    go_r  = 1'b0;
    lmask = '0;
    rmask = '0;
    node  = 0;
    base  = 0;
    span  = WAYS;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !vmask[i] && avail[i]) begin
        way   = WAY_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
        span = span / 2;
        for (int i = 0; i < WAYS; i++) begin
          lmask[i] = (i >= base) && (i < base + span);
          rmask[i] = (i >= base + span) && (i < base + 2 * span);
        end
        // Steer around a subtree whose every way is locked.
        go_r = tree[node];
        if (go_r && ~|(avail & rmask))       go_r = 1'b0;
        else if (!go_r && ~|(avail & lmask)) go_r = 1'b1;
        if (go_r) begin
          base = base + span;
          node = node_right(node);
        end else begin
          node = node_left(node);
        end
      end
      way = WAY_W'(base);
    end
`ifdef RV64G_L1_PLRU_LOCK_EN
    if (~|avail) begin
      way  = '0;
      none = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/rv64g_l1_plru_gen.sv
// Per-set tree-PLRU state with init sweep, access update and registered victim
// response. Optional way locking under RV64G_L1_PLRU_LOCK_EN.
module rv64g_l1_plru_gen
  import rv64g_l1_pkg::*;
#(
  parameter int SETS    = DEF_SETS,
  parameter int WAYS    = DEF_WAYS,
  parameter int INDEX_W = $clog2(SETS),
  parameter int WAY_W   = $clog2(WAYS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               ready_o,
  input  logic               acc_valid_i,
  input  logic [INDEX_W-1:0] acc_set_i,
  input  logic [WAY_W-1:0]   acc_way_i,
  input  logic               vreq_valid_i,
  input  logic [INDEX_W-1:0] vreq_set_i,
  input  logic [WAYS-1:0]    vreq_vmask_i,
  input  logic [WAYS-1:0]    lock_mask_i,
  output logic               vrsp_valid_o,
  output logic [WAY_W-1:0]   vrsp_way_o,
  output logic               vrsp_none_o
);

  plru_state_e        state;
  logic [INDEX_W-1:0] sweep;
  logic [WAYS-2:0]    mem [SETS];
  logic [WAYS-2:0]    acc_next;
  logic               acc_en;
  logic               vreq_en;
  logic [WAY_W-1:0]   pick_way;
  logic               pick_none;

  assign ready_o = (state == PLRU_RUN);
  assign acc_en  = acc_valid_i && ready_o && !flush_i;
  assign vreq_en = vreq_valid_i && ready_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= PLRU_INIT;
      sweep <= '0;
    end else if (flush_i) begin
      state <= PLRU_INIT;
      sweep <= '0;
    end else if (state == PLRU_INIT) begin
      if (sweep == INDEX_W'(SETS - 1)) state <= PLRU_RUN;
      else                             sweep <= sweep + 1'b1;
    end
  end

  // Every node on the accessed path points at the sibling subtree.
  always_comb begin
    int node;
    logic b;
    acc_next = mem[acc_set_i];
    node     = 0;
    b        = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b              = acc_way_i[WAY_W-1-lvl];
      acc_next[node] = ~b;
      node           = b ? node_right(node) : node_left(node);
    end
  end

  // No reset on the array so it can map onto SRAM; the sweep clears it.
  always_ff @(posedge clk_i) begin
    if (state == PLRU_INIT) mem[sweep]     <= '0;
    else if (acc_en)        mem[acc_set_i] <= acc_next;
  end

  rv64g_l1_plru_pick #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_pick (
    .tree      (mem[vreq_set_i]),
    .vmask     (vreq_vmask_i),
    .lock_mask (lock_mask_i),
    .way       (pick_way),
    .none      (pick_none)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vrsp_valid_o <= 1'b0;
      vrsp_way_o   <= '0;
      vrsp_none_o  <= 1'b0;
    end else begin
      vrsp_valid_o <= vreq_en;
      if (vreq_en) begin
        vrsp_way_o  <= pick_way;
        vrsp_none_o <= pick_none;
      end
    end
  end

endmodule

// File: tb/tb_rv64g_l1_plru_gen.sv
// Self-checking bench for rv64g_l1_plru_gen against a recency-timestamp PLRU model.
module tb_rv64g_l1_plru_gen;

  localparam int SETS = 32;
  localparam int WAYS = 8;
  localparam int IW   = 5;
  localparam int WW   = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          ready_o;
  logic          acc_valid_i = 1'b0;
  logic [IW-1:0] acc_set_i = '0;
  logic [WW-1:0] acc_way_i = '0;
  logic          vreq_valid_i = 1'b0;
  logic [IW-1:0] vreq_set_i = '0;
  logic [WAYS-1:0] vreq_vmask_i = '1;
  logic [WAYS-1:0] lock_mask_i = '0;
  logic          vrsp_valid_o;
  logic [WW-1:0] vrsp_way_o;
  logic          vrsp_none_o;

  int n_pass = 0;
  int n_total = 0;

  // Model: a node's LRU side is the subtree whose latest access is older.
  int unsigned ts [SETS][WAYS];
  int unsigned now_t = 0;

  rv64g_l1_plru_gen #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ready_o(ready_o),
    .acc_valid_i(acc_valid_i), .acc_set_i(acc_set_i), .acc_way_i(acc_way_i),
    .vreq_valid_i(vreq_valid_i), .vreq_set_i(vreq_set_i),
    .vreq_vmask_i(vreq_vmask_i), .lock_mask_i(lock_mask_i),
    .vrsp_valid_o(vrsp_valid_o), .vrsp_way_o(vrsp_way_o), .vrsp_none_o(vrsp_none_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) ts[s][w] = 0;
  endfunction

  function automatic void model_access(input int s, input int w);
    now_t++;
    ts[s][w] = now_t;
  endfunction

  function automatic int model_victim(input int s, input logic [WAYS-1:0] vm,
                                      input logic [WAYS-1:0] lk, output logic none);
    logic [WAYS-1:0] av;
    int lo, span, half;
    int unsigned lmax, rmax;
    logic lok, rok, right;
`ifdef RV64G_L1_PLRU_LOCK_EN
    av = ~lk;
`else
    av = '1 | lk;
`endif
    none = 1'b0;
    if (av == '0) begin
      none = 1'b1;
      return 0;
    end
    for (int i = 0; i < WAYS; i++) if (!vm[i] && av[i]) return i;
    lo = 0;
    span = WAYS;
    while (span > 1) begin
      half = span / 2;
      lmax = 0; rmax = 0; lok = 1'b0; rok = 1'b0;
      for (int i = 0; i < half; i++) begin
        if (ts[s][lo+i] > lmax) lmax = ts[s][lo+i];
        if (ts[s][lo+half+i] > rmax) rmax = ts[s][lo+half+i];
        lok |= av[lo+i];
        rok |= av[lo+half+i];
      end
      right = (lmax > rmax);
      if (right && !rok) right = 1'b0;
      else if (!right && !lok) right = 1'b1;
      if (right) lo = lo + half;
      span = half;
    end
    return lo;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0;
    acc_valid_i = 1'b0;
    vreq_valid_i = 1'b0;
    vreq_vmask_i = '1;
    lock_mask_i = '0;
  endtask

  task automatic test_reset();
    int low;
    logic saw;
    idle();
    rst_ni = 1'b0;
    #1;
    n_total++; if (ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", ready_o); else n_pass++;
    n_total++; if (vrsp_valid_o !== 1'b0) $display("FAIL reset_vrsp_valid got %b want 0", vrsp_valid_o); else n_pass++;
    n_total++; if (vrsp_way_o !== 3'd0) $display("FAIL reset_vrsp_way got %0d want 0", vrsp_way_o); else n_pass++;
    n_total++; if (vrsp_none_o !== 1'b0) $display("FAIL reset_vrsp_none got %b want 0", vrsp_none_o); else n_pass++;
    tick();
    rst_ni = 1'b1;
    vreq_valid_i = 1'b1;
    low = 0;
    saw = 1'b0;
    while (!ready_o && low < 200) begin
      low++;
      tick();
      if (vrsp_valid_o) saw = 1'b1;
    end
    vreq_valid_i = 1'b0;
    n_total++; if (low !== 32) $display("FAIL reset_sweep_len got %0d want 32", low); else n_pass++;
    n_total++; if (saw !== 1'b0) $display("FAIL init_req_ignored got rsp %b want 0", saw); else n_pass++;
    model_clear();
    tick();
  endtask

  task automatic test_lru_order();
    for (int w = 0; w < WAYS; w++) begin
      acc_valid_i = 1'b1; acc_set_i = 5'd3; acc_way_i = WW'(w);
      tick();
      model_access(3, w);
    end
    acc_valid_i = 1'b0;
    vreq_valid_i = 1'b1; vreq_set_i = 5'd3; vreq_vmask_i = '1;
    tick();
    vreq_valid_i = 1'b0;
    n_total++; if (vrsp_valid_o !== 1'b1) $display("FAIL order_valid got %b want 1", vrsp_valid_o); else n_pass++;
    n_total++; if (vrsp_way_o !== 3'd0) $display("FAIL order_victim got %0d want 0", vrsp_way_o); else n_pass++;
    acc_valid_i = 1'b1; acc_way_i = 3'd0;
    tick();
    model_access(3, 0);
    acc_valid_i = 1'b0;
    vreq_valid_i = 1'b1;
    tick();
    vreq_valid_i = 1'b0;
    n_total++; if (vrsp_way_o !== 3'd4) $display("FAIL order_after_way0 got %0d want 4", vrsp_way_o); else n_pass++;
    tick();
    n_total++; if (vrsp_valid_o !== 1'b0) $display("FAIL single_pulse got %b want 0", vrsp_valid_o); else n_pass++;
    n_total++; if (vrsp_way_o !== 3'd4) $display("FAIL hold_way got %0d want 4", vrsp_way_o); else n_pass++;
  endtask

  task automatic test_vmask();
    vreq_valid_i = 1'b1; vreq_set_i = 5'd10; vreq_vmask_i = 8'b1111_1011;
    #1;
    n_total++; if (vrsp_valid_o !== 1'b0) $display("FAIL vmask_early got %b want 0", vrsp_valid_o); else n_pass++;
    tick();
    vreq_valid_i = 1'b0; vreq_vmask_i = '1;
    n_total++; if (vrsp_valid_o !== 1'b1) $display("FAIL vmask_valid got %b want 1", vrsp_valid_o); else n_pass++;
    n_total++; if (vrsp_way_o !== 3'd2) $display("FAIL vmask_victim got %0d want 2", vrsp_way_o); else n_pass++;
  endtask

  task automatic test_same_cycle();
    acc_valid_i = 1'b1; acc_set_i = 5'd5; acc_way_i = 3'd0;
    vreq_valid_i = 1'b1; vreq_set_i = 5'd5; vreq_vmask_i = '1;
    tick();
    model_access(5, 0);
    acc_valid_i = 1'b0;
    n_total++; if (vrsp_way_o !== 3'd0) $display("FAIL same_cycle_pre got %0d want 0", vrsp_way_o); else n_pass++;
    tick();
    vreq_valid_i = 1'b0;
    n_total++; if (vrsp_way_o !== 3'd4) $display("FAIL same_cycle_post got %0d want 4", vrsp_way_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_way;
    logic exp_none, want_rsp;
    for (int c = 0; c < 400; c++) begin
      acc_valid_i  = ($urandom_range(0, 1) == 1);
      acc_set_i    = IW'($urandom_range(0, 3));
      acc_way_i    = WW'($urandom_range(0, WAYS - 1));
      vreq_valid_i = ($urandom_range(0, 9) < 7);
      vreq_set_i   = IW'($urandom_range(0, 3));
      vreq_vmask_i = ($urandom_range(0, 1) == 1) ? '1 : WAYS'($urandom);
      lock_mask_i  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
      want_rsp = vreq_valid_i;
      exp_way = model_victim(int'(vreq_set_i), vreq_vmask_i, lock_mask_i, exp_none);
      tick();
      if (acc_valid_i) model_access(int'(acc_set_i), int'(acc_way_i));
      n_total++;
      if (vrsp_valid_o !== want_rsp) $display("FAIL b2b_valid c=%0d got %b want %b", c, vrsp_valid_o, want_rsp);
      else n_pass++;
      if (want_rsp) begin
        n_total++;
        if (vrsp_way_o !== WW'(exp_way) || vrsp_none_o !== exp_none)
          $display("FAIL b2b_victim c=%0d got way %0d none %b want way %0d none %b",
                   c, vrsp_way_o, vrsp_none_o, exp_way, exp_none);
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_flush();
    int low;
    vreq_valid_i = 1'b1; vreq_set_i = 5'd1; vreq_vmask_i = '1;
    tick();
    flush_i = 1'b1;
    n_total++; if (vrsp_valid_o !== 1'b1) $display("FAIL inflight_rsp got %b want 1", vrsp_valid_o); else n_pass++;
    tick();
    flush_i = 1'b0; vreq_valid_i = 1'b0;
    n_total++; if (vrsp_valid_o !== 1'b0) $display("FAIL flush_drop got %b want 0", vrsp_valid_o); else n_pass++;
    low = 0;
    while (!ready_o && low < 200) begin
      low++;
      tick();
    end
    n_total++; if (low !== 32) $display("FAIL flush_sweep_len got %0d want 32", low); else n_pass++;
    model_clear();
    for (int s = 0; s < SETS; s++) begin
      vreq_valid_i = 1'b1; vreq_set_i = IW'(s); vreq_vmask_i = '1;
      tick();
      n_total++;
      if (vrsp_valid_o !== 1'b1 || vrsp_way_o !== 3'd0)
        $display("FAIL flush_readback set %0d got v=%b way %0d want v=1 way 0", s, vrsp_valid_o, vrsp_way_o);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_mid_reset();
    int low;
    vreq_valid_i = 1'b1; vreq_set_i = 5'd2; vreq_vmask_i = 8'h7F;
    tick();
    vreq_valid_i = 1'b0; vreq_vmask_i = '1;
    n_total++; if (vrsp_way_o !== 3'd7) $display("FAIL pre_reset_way got %0d want 7", vrsp_way_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++;
    if (vrsp_valid_o !== 1'b0 || vrsp_way_o !== 3'd0 || ready_o !== 1'b0)
      $display("FAIL mid_rsp_reset got v=%b way %0d rdy %b want 0 0 0", vrsp_valid_o, vrsp_way_o, ready_o);
    else n_pass++;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_ni = 1'b0;
    #1;
    n_total++; if (ready_o !== 1'b0) $display("FAIL mid_sweep_reset got rdy %b want 0", ready_o); else n_pass++;
    tick();
    rst_ni = 1'b1;
    low = 0;
    while (!ready_o && low < 200) begin
      low++;
      tick();
    end
    n_total++; if (low !== 32) $display("FAIL resweep_len got %0d want 32", low); else n_pass++;
    model_clear();
  endtask

`ifdef RV64G_L1_PLRU_LOCK_EN
  task automatic test_lock();
    vreq_valid_i = 1'b1; vreq_set_i = 5'd9; vreq_vmask_i = '1; lock_mask_i = 8'h0F;
    tick();
    n_total++; if (vrsp_way_o !== 3'd4 || vrsp_none_o !== 1'b0)
      $display("FAIL lock_low got way %0d none %b want 4 0", vrsp_way_o, vrsp_none_o); else n_pass++;
    lock_mask_i = 8'hFF;
    tick();
    n_total++; if (vrsp_way_o !== 3'd0 || vrsp_none_o !== 1'b1)
      $display("FAIL lock_all got way %0d none %b want 0 1", vrsp_way_o, vrsp_none_o); else n_pass++;
    idle();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_lru_order();
    test_vmask();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_mid_reset();
`ifdef RV64G_L1_PLRU_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
